// File: rtl/event_bus_reader.sv
// rtl/event_bus_reader.sv - cluster-side reader of the token ring event bus
// Optional occupancy output evt_level_o is built when EVENT_BUS_READER_LEVEL_EN is defined.
module event_bus_reader #(
  parameter int BUFFER_WIDTH = 8,
  parameter int EVNT_WIDTH   = 8,
  parameter int SYNC_STAGES  = 2,
  localparam int IDX_W       = (BUFFER_WIDTH > 1) ? $clog2(BUFFER_WIDTH) : 1,
  localparam int LEVEL_W     = $clog2(BUFFER_WIDTH + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [BUFFER_WIDTH-1:0]            events_wt_i,
  input  logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] events_da_i,
  output logic [BUFFER_WIDTH-1:0]            events_rp_o,
  output logic                               evt_valid_o,
  output logic [EVNT_WIDTH-1:0]              evt_data_o,
  input  logic                               evt_ready_i
`ifdef EVENT_BUS_READER_LEVEL_EN
  ,
  output logic [LEVEL_W-1:0]                 evt_level_o
`endif
);

  logic [BUFFER_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [BUFFER_WIDTH-1:0] wt_sync;
  logic [BUFFER_WIDTH-1:0] rp_q;
  logic [BUFFER_WIDTH-1:0] full;
  logic [IDX_W-1:0]        rd_idx;
  logic [EVNT_WIDTH-1:0]   slots [BUFFER_WIDTH];
  logic                    load;

  // Tokens enter straight into the first flop; the writer guarantees single-bit changes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= events_wt_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wt_sync = sync_q[SYNC_STAGES-1];
  assign full    = wt_sync ^ rp_q;

  always_comb begin
    for (int i = 0; i < BUFFER_WIDTH; i++) slots[i] = events_da_i[i*EVNT_WIDTH +: EVNT_WIDTH];
  end

  assign load = full[rd_idx] & (~evt_valid_o | evt_ready_i);

  // The slot is released as soon as it is copied into the output register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rp_q        <= '0;
      rd_idx      <= '0;
      evt_valid_o <= 1'b0;
      evt_data_o  <= '0;
    end else if (load) begin
      evt_data_o  <= slots[rd_idx];
      evt_valid_o <= 1'b1;
      rp_q        <= rp_q ^ (BUFFER_WIDTH'(1) << rd_idx);
      rd_idx      <= (rd_idx == IDX_W'(BUFFER_WIDTH - 1)) ? '0 : rd_idx + 1'b1;
    end else if (evt_valid_o && evt_ready_i) begin
      evt_valid_o <= 1'b0;
    end
  end

  assign events_rp_o = rp_q;

`ifdef EVENT_BUS_READER_LEVEL_EN
  logic [LEVEL_W-1:0] pending;

  always_comb begin
    pending = '0;
    for (int i = 0; i < BUFFER_WIDTH; i++) pending = pending + LEVEL_W'(full[i]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) evt_level_o <= '0;
    else       evt_level_o <= pending;
  end
`endif

endmodule

// File: tb/tb_event_bus_reader.sv
// tb/tb_event_bus_reader.sv - directed bench for event_bus_reader (8 slots, 8-bit events, 2 sync stages)
module tb_event_bus_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  wt;
  logic [63:0] da;
  logic [7:0]  rp;
  logic        valid;
  logic [7:0]  data;
  logic        ready;
`ifdef EVENT_BUS_READER_LEVEL_EN
  logic [3:0]  level;
`endif

  int vectors = 0;
  int miscompares = 0;

  event_bus_reader #(.BUFFER_WIDTH(8), .EVNT_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .events_wt_i (wt),
    .events_da_i (da),
    .events_rp_o (rp),
    .evt_valid_o (valid),
    .evt_data_o  (data),
    .evt_ready_i (ready)
`ifdef EVENT_BUS_READER_LEVEL_EN
    ,
    .evt_level_o (level)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    wt  = 8'h00;
    for (int i = 0; i < cycles; i++) tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; wt = 8'h00; da = '0; ready = 1'b0;
    #1;

    // Reset state
    do_reset(3);
    check("reset_rp", 32'(rp), 32'h00);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_data", 32'(data), 32'h00);
`ifdef EVENT_BUS_READER_LEVEL_EN
    check("reset_level", 32'(level), 32'h0);
`endif

    // Single event: token toggled just after edge 0
    da[7:0] = 8'hA5; ready = 1'b1; wt = 8'h01;
    tick(); check("single_e1_valid", 32'(valid), 32'h0);
    tick(); check("single_e2_valid", 32'(valid), 32'h0);
    tick();
    check("single_e3_valid", 32'(valid), 32'h1);
    check("single_e3_data", 32'(data), 32'hA5);
    check("single_e3_rp", 32'(rp), 32'h01);
    tick();
    check("single_e4_valid", 32'(valid), 32'h0);
    check("single_e4_data_hold", 32'(data), 32'hA5);

    // Burst of 8 with wrap
    do_reset(1);
    for (int i = 0; i < 8; i++) da[i*8 +: 8] = 8'(8'h10 + i);
    ready = 1'b1;
    wt[0] = ~wt[0];
    for (int t = 1; t <= 11; t++) begin
      tick();
      if (t >= 3 && t <= 10) begin
        check("burst_valid", 32'(valid), 32'h1);
        check("burst_data", 32'(data), 32'(8'h10 + t - 3));
      end
      if (t == 10) check("burst_rp", 32'(rp), 32'hFF);
      if (t == 11) check("burst_drain_valid", 32'(valid), 32'h0);
      if (t < 8) wt[t] = ~wt[t];
    end
    da[7:0] = 8'h20; wt[0] = ~wt[0];
    tick(); tick(); tick();
    check("wrap_valid", 32'(valid), 32'h1);
    check("wrap_data", 32'(data), 32'h20);
    check("wrap_rp", 32'(rp), 32'hFE);

    // Backpressure
    do_reset(1);
    da[7:0] = 8'h01; da[15:8] = 8'h02; da[23:16] = 8'h03;
    ready = 1'b0;
    wt[0] = 1'b1; tick();
    wt[1] = 1'b1; tick();
    wt[2] = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("bp_valid", 32'(valid), 32'h1);
    check("bp_data", 32'(data), 32'h01);
    check("bp_rp", 32'(rp), 32'h01);
`ifdef EVENT_BUS_READER_LEVEL_EN
    check("bp_level", 32'(level), 32'h2);
`endif
    ready = 1'b1;
    tick();
    check("bp_rel1_data", 32'(data), 32'h02);
    check("bp_rel1_valid", 32'(valid), 32'h1);
    tick();
    check("bp_rel2_data", 32'(data), 32'h03);
    check("bp_rel2_rp", 32'(rp), 32'h07);
    tick();
    check("bp_rel3_valid", 32'(valid), 32'h0);

    // Reset mid-stream
    do_reset(1);
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      da[i*8 +: 8] = 8'(8'h40 + i);
      wt[i] = 1'b1;
      tick();
    end
    tick(); tick(); tick();
    check("mid_pre_valid", 32'(valid), 32'h1);
    check("mid_pre_data", 32'(data), 32'h40);
    do_reset(1);
    check("mid_rst_valid", 32'(valid), 32'h0);
    check("mid_rst_rp", 32'(rp), 32'h00);
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mid_no_stale", 32'(valid), 32'h0);
    end
    check("mid_post_rp", 32'(rp), 32'h00);

`ifdef EVENT_BUS_READER_LEVEL_EN
    // Level tracking
    do_reset(1);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      da[i*8 +: 8] = 8'(8'h60 + i);
      wt[i] = 1'b1;
      tick();
    end
    for (int i = 0; i < 6; i++) tick();
    check("lvl_settled", 32'(level), 32'h4);
    ready = 1'b1;
    tick(); check("lvl_step0", 32'(level), 32'h4);
    tick(); check("lvl_step1", 32'(level), 32'h3);
    tick(); check("lvl_step2", 32'(level), 32'h2);
    tick(); check("lvl_step3", 32'(level), 32'h1);
    tick(); check("lvl_step4", 32'(level), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
